// File: rtl/mem_access_sequencer_if.sv
// Bundle of the MEM-stage request signals and the byte-wide data memory port
// used by mem_access_sequencer. The slave modport is the sequencer's view;
// the master modport is the view of the environment (pipeline + memory).
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 16
);
  // Pipeline side
  logic              MemRead;
  logic              MemWrite;
  logic              wordOrByte;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic              stall;
  logic              err;
  // Data memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport slave (
    input  MemRead, MemWrite, wordOrByte, addr, wdata, mem_rdata, mem_ready,
    output rdata, rdata_valid, stall, err, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output MemRead, MemWrite, wordOrByte, addr, wdata, mem_rdata, mem_ready,
    input  rdata, rdata_valid, stall, err, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multi-cycle sequencer between the MEM stage and a byte-wide data memory.
// Loads/stores are split into 4 byte beats (word) or 1 beat (byte); stall is
// held until the access completes. Byte loads are sign-extended.
// Optional macro MEM_SEQ_TIMEOUT_EN: per-beat wait counter that aborts a beat
// after TIMEOUT_CYCLES cycles of mem_ready low, setting err.
module mem_access_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  mem_access_sequencer_if.slave bus
);

  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("mem_access_sequencer: ADDR_W must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              op_write_q, op_write_d;
  logic              op_word_q, op_word_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lanes_q, lanes_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  logic              stall_c;
  logic              rdata_valid_c;
  logic              mem_re_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [7:0]        mem_wdata_c;
  logic              last_beat;

  assign last_beat = op_word_q ? (beat_q == 2'd3) : 1'b1;

  // Next-state and output decode for the IDLE/ACCESS/DONE sequencer
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    op_write_d    = op_write_q;
    op_word_d     = op_word_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    lanes_d       = lanes_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
`ifdef MEM_SEQ_TIMEOUT_EN
    wait_d        = wait_q;
`endif
    stall_c       = 1'b0;
    rdata_valid_c = 1'b0;
    mem_re_c      = 1'b0;
    mem_we_c      = 1'b0;
    mem_addr_c    = '0;
    mem_wdata_c   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          stall_c    = 1'b1;
          op_write_d = bus.MemWrite;
          op_word_d  = bus.wordOrByte;
          base_d     = bus.wordOrByte ? {bus.addr[ADDR_W-1:2], 2'b00} : bus.addr;
          wdata_d    = bus.wdata;
          beat_d     = '0;
          if (bus.wordOrByte && (bus.addr[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end
`ifdef MEM_SEQ_TIMEOUT_EN
          wait_d     = '0;
`endif
          state_d    = S_ACCESS;
        end
      end

      S_ACCESS: begin
        stall_c     = 1'b1;
        mem_re_c    = ~op_write_q;
        mem_we_c    = op_write_q;
        mem_addr_c  = base_q + ADDR_W'(beat_q);
        mem_wdata_c = wdata_q[{beat_q, 3'b000} +: 8];
        if (bus.mem_ready) begin
          if (!op_write_q) begin
            lanes_d[{beat_q, 3'b000} +: 8] = bus.mem_rdata;
          end
          beat_d = beat_q + 2'd1;
`ifdef MEM_SEQ_TIMEOUT_EN
          wait_d = '0;
`endif
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_DONE;
            // rdata is loaded on the final beat so it is already valid in DONE
            if (!op_write_q) begin
              rdata_d = op_word_q ? lanes_d : {{24{lanes_d[7]}}, lanes_d[7:0]};
            end
          end
        end
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          beat_d  = '0;
          state_d = S_DONE;
          if (!op_write_q) begin
            rdata_d = '0;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end

      S_DONE: begin
        // The request that produced this access is still on the inputs here,
        // so they are deliberately not looked at.
        rdata_valid_c = ~op_write_q;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      op_write_q <= 1'b0;
      op_word_q  <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      lanes_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      op_write_q <= op_write_d;
      op_word_q  <= op_word_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      lanes_q    <= lanes_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef MEM_SEQ_TIMEOUT_EN
      wait_q     <= wait_d;
`endif
    end
  end

  assign bus.stall       = stall_c;
  assign bus.rdata_valid = rdata_valid_c;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_re      = mem_re_c;
  assign bus.mem_we      = mem_we_c;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: stimulus pushes expected memory
// beats and load results; a responder/monitor pops and compares them.
module tb_mem_access_sequencer;

  localparam int ADDR_W = 16;
`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_sequencer #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  logic [7:0] mem_arr [0:65535];
  assign bus.mem_rdata = mem_arr[bus.mem_addr];

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rd[$];
  int          wait_left[8];
  int          beat_idx;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Memory responder: chooses mem_ready for the next edge, checks accepted beats
  initial begin : responder
    beat_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_re || bus.mem_we) begin
        if (wait_left[beat_idx] > 0) begin
          bus.mem_ready = 1'b0;
          wait_left[beat_idx]--;
        end else begin
          bus.mem_ready = 1'b1;
          if (beat_idx < 7) beat_idx++;
          if (exp_beats.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got addr %h we %b, required no beat", bus.mem_addr, bus.mem_we);
          end else begin
            e = exp_beats.pop_front();
            check("beat_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("beat_we", 32'(bus.mem_we), 32'(e.we));
            if (e.we) begin
              check("beat_wdata", 32'(bus.mem_wdata), 32'(e.data));
              mem_arr[bus.mem_addr] = bus.mem_wdata;
            end
          end
        end
      end else begin
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Load-result monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.rdata_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_valid_unexpected: got rdata %h, required no valid", bus.rdata);
        end else begin
          check("rdata", bus.rdata, exp_rd.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic drop_req();
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.wordOrByte = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
  endtask

  task automatic do_access(input string name, input bit rd, input bit wr, input bit word,
                           input logic [15:0] a, input logic [31:0] wd,
                           input int w0, input int w1, input int w2, input int w3,
                           input logic [15:0] exp_base, input int n_beats,
                           input bit exp_load, input logic [31:0] exp_val,
                           input int exp_lat, input bit exp_err,
                           input bit hold, input bit scramble);
    int lat;
    bit done;
    wait_left = '{w0, w1, w2, w3, 0, 0, 0, 0};
    beat_idx  = 0;
    for (int i = 0; i < n_beats; i++) begin
      exp_beats.push_back('{exp_base + 16'(i), wr, wd[8*i +: 8]});
    end
    if (exp_load) exp_rd.push_back(exp_val);
    @(negedge clk);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.wordOrByte = word;
    bus.addr       = a;
    bus.wdata      = wd;
    #1 check({name, "_stall_req"}, 32'(bus.stall), 32'd1);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!bus.stall) begin
        done = 1'b1;
      end else if (scramble) begin
        bus.addr  = 16'h5A5A ^ 16'(lat);
        bus.wdata = 32'h0BAD_F00D + 32'(lat);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_complete: stall still high after %0d cycles, required completion", name, lat);
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_err"}, 32'(bus.err), 32'(exp_err));
    check({name, "_done_strobes"}, 32'({bus.mem_re, bus.mem_we}), 32'd0);
    if (hold) begin
      @(negedge clk);
      check({name, "_hold_no_access"}, 32'({bus.mem_re, bus.mem_we}), 32'd0);
      check({name, "_hold_reaccept"}, 32'(bus.stall), 32'd1);
      drop_req();
      #1 check({name, "_hold_release"}, 32'(bus.stall), 32'd0);
      @(negedge clk);
      check({name, "_hold_idle"}, 32'({bus.stall, bus.mem_re, bus.mem_we}), 32'd0);
    end else begin
      drop_req();
    end
  endtask

  initial begin : stimulus
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'h00;
    mem_arr[16'h0010] = 8'h78;
    mem_arr[16'h0011] = 8'h56;
    mem_arr[16'h0012] = 8'h34;
    mem_arr[16'h0013] = 8'h12;
    mem_arr[16'h0021] = 8'h80;
    for (int i = 0; i < 8; i++) wait_left[i] = 0;
    beat_idx = 0;
    rst_n = 1'b0;
    drop_req();
    repeat (2) @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_outs", 32'({bus.stall, bus.rdata_valid, bus.mem_re, bus.mem_we, bus.err}), 32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // name rd wr word addr wdata waits base beats load val lat err hold scramble
    do_access("lw_aligned", 1, 0, 1, 16'h0010, 32'h0, 0, 0, 0, 0, 16'h0010, 4, 1, 32'h1234_5678, 5, 0, 0, 0);
    do_access("lb_sext",    1, 0, 0, 16'h0021, 32'h0, 0, 0, 0, 0, 16'h0021, 1, 1, 32'hFFFF_FF80, 2, 0, 0, 0);
    do_access("sw_wait",    0, 1, 1, 16'h0040, 32'hDEAD_BEEF, 0, 2, 0, 0, 16'h0040, 4, 0, 32'h0, 7, 0, 0, 1);
    check("rdata_hold", bus.rdata, 32'hFFFF_FF80);
    do_access("lw_held",    1, 0, 1, 16'h0040, 32'h0, 0, 0, 0, 0, 16'h0040, 4, 1, 32'hDEAD_BEEF, 5, 0, 1, 0);
    do_access("rw_both",    1, 1, 0, 16'h0051, 32'h0000_00A5, 0, 0, 0, 0, 16'h0051, 1, 0, 32'h0, 2, 0, 0, 0);
    do_access("lb_after_sb",1, 0, 0, 16'h0051, 32'h0, 0, 0, 0, 0, 16'h0051, 1, 1, 32'hFFFF_FFA5, 2, 0, 0, 0);
    do_access("lb_wait3",   1, 0, 0, 16'h0042, 32'h0, 3, 0, 0, 0, 16'h0042, 1, 1, 32'hFFFF_FFAD, 5, 0, 0, 0);
    do_access("lb_pos",     1, 0, 0, 16'h0013, 32'h0, 0, 0, 0, 0, 16'h0013, 1, 1, 32'h0000_0012, 2, 0, 0, 0);
    do_access("lw_misalign",1, 0, 1, 16'h0013, 32'h0, 0, 0, 0, 0, 16'h0010, 4, 1, 32'h1234_5678, 5, 1, 0, 0);
`ifdef MEM_SEQ_TIMEOUT_EN
    do_access("lw_timeout", 1, 0, 1, 16'h0010, 32'h0, 1000, 0, 0, 0, 16'h0010, 0, 1, 32'h0, 5, 1, 0, 0);
`endif

    // Reset asserted while beat 2 of a word load is on the bus
    for (int i = 0; i < 8; i++) wait_left[i] = 0;
    beat_idx = 0;
    for (int i = 0; i < 3; i++) exp_beats.push_back('{16'h0010 + 16'(i), 1'b0, 8'h00});
    @(negedge clk);
    bus.MemRead    = 1'b1;
    bus.wordOrByte = 1'b1;
    bus.addr       = 16'h0010;
    repeat (3) @(negedge clk);
    check("midrst_beat2_addr", 32'(bus.mem_addr), 32'h0012);
    #2 rst_n = 1'b0;
    drop_req();
    #1;
    check("midrst_outs", 32'({bus.stall, bus.mem_re, bus.mem_we, bus.rdata_valid, bus.err}), 32'd0);
    check("midrst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_idle", 32'({bus.stall, bus.mem_re, bus.mem_we}), 32'd0);

    do_access("lb_postrst", 1, 0, 0, 16'h0021, 32'h0, 0, 0, 0, 0, 16'h0021, 1, 1, 32'hFFFF_FF80, 2, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("beats_pending", 32'(exp_beats.size()), 32'd0);
    check("loads_pending", 32'(exp_rd.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
